fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the word address into the instruction memory and captures the returned word into the IF/ID pipeline register for decode.
- Owns the program counter (PC), sequential increment, branch/jump redirect, stall hold and halt detection.
- Instruction memory read is asynchronous, so fetch and capture happen in the same cycle.

Parameters:
- ADDR_WIDTH, 6, word-address width of the instruction memory and of the PC.
- DATA_WIDTH, 32, instruction word width.
- CNT_WIDTH, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_WIDTH  current PC, driven to the instruction memory address input.
- imem_data  in  DATA_WIDTH  instruction word for imem_addr, valid in the same cycle.
- stall  in  1  decode/hazard unit requests hold of PC and IF/ID.
- redirect_valid  in  1  taken branch or jump resolved downstream.
- redirect_target  in  ADDR_WIDTH  new PC word address.
- ifid_valid  out  1  IF/ID register holds a real instruction.
- ifid_instr  out  DATA_WIDTH  captured instruction.
- ifid_pc  out  ADDR_WIDTH  address the instruction was fetched from.
- ifid_pc_plus1  out  ADDR_WIDTH  ifid_pc+1 mod 2**ADDR_WIDTH, for link and branch-offset calculation.
- halted  out  1  fetch has stopped on HALT_WORD.
- fetch_count  out  CNT_WIDTH  number of instructions delivered with ifid_valid=1.

Behaviour:
- Reset (async assert, sync use after release):
  - pc=0, ifid_valid=0, ifid_instr=NOP_WORD (all zeros), ifid_pc=0, ifid_pc_plus1=0, halted=0, fetch_count=0.
  - FSM enters RUN.
- imem_addr = pc, combinational from the register. It has no dependency on imem_data.
- FSM states:
  - RUN, normal fetch.
  - HALT, fetch frozen.
- RUN, per cycle, in priority order:
  1. redirect_valid=1:
     - pc<=redirect_target.
     - ifid_valid<=0 and ifid_instr<=NOP_WORD, which flushes the wrong-path word.
     - ifid_pc and ifid_pc_plus1 hold.
     - Redirect overrides stall.
  2. stall=1: pc and all IF/ID fields hold their values.
  3. Otherwise:
     - ifid_instr<=imem_data, ifid_pc<=pc, ifid_pc_plus1<=pc+1, ifid_valid<=1.
     - pc<=pc+1, wrapping from 2**ADDR_WIDTH-1 to 0.
     - If imem_data==HALT_WORD (all ones): pc holds instead of incrementing, and the next state is HALT. The HALT word itself is delivered with ifid_valid=1.
- HALT:
  - halted=1 and pc holds.
  - With stall=0: ifid_valid<=0 and ifid_instr<=NOP_WORD, so the halt word drains once.
  - With stall=1: IF/ID holds.
  - redirect_valid=1: pc<=redirect_target, flush IF/ID, next state RUN, halted<=0 on the same edge.
  - Only redirect or reset leave HALT.
- fetch_count:
  - Increments by 1 on every edge where ifid_valid is loaded with 1 from a fresh fetch (case 3).
  - Saturates at 2**CNT_WIDTH-1.
  - It does not increment on stall, flush or HALT cycles.
- Simultaneous events:
  - stall+redirect: redirect wins.
  - A redirect in the cycle HALT_WORD is at imem_addr: the redirect wins, there is no halt, and the word is discarded.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). The first fetch after release is from address 0.
- Arithmetic is unsigned modulo 2**ADDR_WIDTH. No out-of-range address is possible.

Decomposition:
- Shared package fetch_pkg:
  - HALT_WORD = {DATA_WIDTH{1'b1}}, NOP_WORD = 0.
  - FSM state enum {RUN, HALT}.
  - Default widths.
- One natural sub-module, ifid_reg: the IF/ID pipeline register with load, flush and hold controls. The PC, FSM and counter stay in fetch_unit.

Test Plan:
- Reset, then a program of words 0x11,0x22,0x33 at addresses 0-2, no stall -> imem_addr sequence 0,1,2,3. ifid_instr=0x11,0x22,0x33 on consecutive cycles with ifid_valid=1. fetch_count=3.
- stall=1 for 2 cycles while pc=2 -> imem_addr stays 2, IF/ID holds 0x22/pc 1, fetch_count unchanged. Resume -> 0x33 delivered.
- redirect_valid=1 with target=40 while stall=1 -> next imem_addr=40, ifid_valid=0, ifid_instr=0. The following cycle delivers mem[40] with ifid_pc=40, ifid_pc_plus1=41.
- pc reaches 63 -> ifid_pc_plus1=0, next imem_addr=0 (wrap).
- HALT_WORD at address 5 -> it is delivered once with valid=1, then ifid_valid=0, halted=1, imem_addr stays 5. Redirect to 0 -> halted=0 and fetch restarts at 0.
- Assert rst_n=0 asynchronously mid-cycle at pc=9 -> all outputs return to reset values before the next edge. Release -> fetch from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, special instruction words and fetch FSM states
package fetch_pkg;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int CNT_W = 16;
   localparam logic [DATA_W-1:0] HALT_WORD = '1;
   localparam logic [DATA_W-1:0] NOP_WORD = '0;
   typedef enum logic {RUN, HALT} state_e;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush-over-load priority and hold otherwise
module ifid_reg import fetch_pkg::*; #(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [ADDR_WIDTH-1:0] pc_plus1_o
);
   // flush kills the instruction but keeps its address; load captures a fresh fetch
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid_o <= 1'b0;
         instr_o <= '0;
         pc_o <= '0;
         pc_plus1_o <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
         instr_o <= '0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         instr_o <= instr_i;
         pc_o <= pc_i;
         pc_plus1_o <= pc_i + ADDR_WIDTH'(1);
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, redirect/stall/halt control and retired-fetch counter feeding the IF/ID register
module fetch_unit import fetch_pkg::*; #(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int CNT_WIDTH = CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_data_i,
   input  logic                  stall_i,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_target_i,
   output logic                  ifid_valid_o,
   output logic [DATA_WIDTH-1:0] ifid_instr_o,
   output logic [ADDR_WIDTH-1:0] ifid_pc_o,
   output logic [ADDR_WIDTH-1:0] ifid_pc_plus1_o,
   output logic                  halted_o,
   output logic [CNT_WIDTH-1:0]  fetch_count_o
);
   state_e state_q;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic halted_q, load, flush, is_halt;
   assign imem_addr_o = pc_q;
   assign halted_o = halted_q;
   assign fetch_count_o = cnt_q;
   // redirect beats stall; a fetched halt word is delivered but freezes the PC
   always_comb begin
      is_halt = &imem_data_i;
      load = state_q == RUN && !redirect_valid_i && !stall_i;
      flush = redirect_valid_i || (state_q == HALT && !stall_i);
      pc_d = redirect_valid_i ? redirect_target_i : (load && !is_halt) ? pc_q + ADDR_WIDTH'(1) : pc_q;
   end
   // FSM with registered halted flag, PC and saturating fetch counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= RUN;
         halted_q <= 1'b0;
         pc_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (load && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
         if (redirect_valid_i) begin
            state_q <= RUN;
            halted_q <= 1'b0;
         end else if (load && is_halt) begin
            state_q <= HALT;
            halted_q <= 1'b1;
         end
      end
   ifid_reg #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ifid (
      .clk(clk),
      .rst_n(rst_n),
      .load_i(load),
      .flush_i(flush),
      .instr_i(imem_data_i),
      .pc_i(pc_q),
      .valid_o(ifid_valid_o),
      .instr_o(ifid_instr_o),
      .pc_o(ifid_pc_o),
      .pc_plus1_o(ifid_pc_plus1_o)
   );
endmodule
